// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD MM:SS stopwatch with pause, clear, field adjust, blink strobe and wrap pulse
// Define COUNTDOWN_EN to add the dir input (count down) and done output.
module stopwatch_core #(
  parameter int SEC_CYCLES = 100000000,
  parameter int ADJ_CYCLES = 50000000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause_pulse,
  input  logic       clr_pulse,
  input  logic       adj,
  input  logic       sel,
`ifdef COUNTDOWN_EN
  input  logic       dir,
  output logic       done,
`endif
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       blink,
  output logic       wrap
);
  localparam int SW = $clog2(SEC_CYCLES);
  localparam int AW = $clog2(ADJ_CYCLES);
  localparam int BW = $clog2(BLINK_CYCLES);
  typedef enum logic {RUN, PAUSED} state_t;
  state_t state;
  logic [SW-1:0] sec_cnt;
  logic [AW-1:0] adj_cnt;
  logic [BW-1:0] blink_cnt;
  logic blink_q, sec_tick, adj_tick, blink_tick, dn, e0, e1, e2, e3, stop;
  function automatic logic [3:0] step(input logic [3:0] d, input logic [3:0] top, input logic down);
    return down ? (d == 4'd0 ? top : d - 4'd1) : (d == top ? 4'd0 : d + 4'd1);
  endfunction
`ifdef COUNTDOWN_EN
  assign dn = dir && running;
`else
  assign dn = 1'b0;
`endif
  assign running = state == RUN && !adj;
  assign blink = adj && blink_q;
  assign sec_tick = running && sec_cnt == SW'(SEC_CYCLES - 1);
  assign adj_tick = adj && adj_cnt == AW'(ADJ_CYCLES - 1);
  assign blink_tick = adj && blink_cnt == BW'(BLINK_CYCLES - 1);
  // e* flag a digit at its rollover value for the current direction
  assign e0 = sec_ones == (dn ? 4'd0 : 4'd9);
  assign e1 = sec_tens == (dn ? 4'd0 : 4'd5);
  assign e2 = min_ones == (dn ? 4'd0 : 4'd9);
  assign e3 = min_tens == (dn ? 4'd0 : 4'd9);
  assign stop = dn && e0 && e1 && e2 && e3;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      {min_tens, min_ones, sec_tens, sec_ones} <= '0;
      sec_cnt <= '0;
      adj_cnt <= '0;
      blink_cnt <= '0;
      blink_q <= 1'b0;
      wrap <= 1'b0;
`ifdef COUNTDOWN_EN
      done <= 1'b0;
`endif
    end else begin
      wrap <= 1'b0;
`ifdef COUNTDOWN_EN
      done <= 1'b0;
`endif
      if (pause_pulse) state <= state == RUN ? PAUSED : RUN;
      sec_cnt <= running && !clr_pulse && !sec_tick ? sec_cnt + SW'(1) : '0;
      adj_cnt <= adj && !clr_pulse && !adj_tick ? adj_cnt + AW'(1) : '0;
      blink_cnt <= adj && !clr_pulse && !blink_tick ? blink_cnt + BW'(1) : '0;
      blink_q <= adj && (blink_q ^ (blink_tick && !clr_pulse));
      if (clr_pulse) begin
        {min_tens, min_ones, sec_tens, sec_ones} <= '0;
      end else if (sec_tick && stop) begin
        state <= PAUSED;
`ifdef COUNTDOWN_EN
        done <= 1'b1;
`endif
      end else if (sec_tick) begin
        sec_ones <= step(sec_ones, 4'd9, dn);
        if (e0) sec_tens <= step(sec_tens, 4'd5, dn);
        if (e0 && e1) min_ones <= step(min_ones, 4'd9, dn);
        if (e0 && e1 && e2) min_tens <= step(min_tens, 4'd9, dn);
        wrap <= !dn && e0 && e1 && e2 && e3;
      end else if (adj_tick && !sel) begin
        sec_ones <= step(sec_ones, 4'd9, 1'b0);
        if (e0) sec_tens <= step(sec_tens, 4'd5, 1'b0);
      end else if (adj_tick) begin
        min_ones <= step(min_ones, 4'd9, 1'b0);
        if (e2) min_tens <= step(min_tens, 4'd9, 1'b0);
      end
    end
  end
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: scoreboard bench; a time-in-seconds reference model predicts every cycle.
module tb_stopwatch_core;
  localparam int SEC = 4, ADJ = 3, BL = 2;
`ifdef COUNTDOWN_EN
  localparam bit CD = 1'b1;
`else
  localparam bit CD = 1'b0;
`endif
  logic clk = 0, rst = 0, pause_pulse = 0, clr_pulse = 0, adj = 0, sel = 0, dir = 0;
  logic done;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic running, blink, wrap;
  typedef struct packed {logic [15:0] dig; logic run, bl, wr, dn;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int m_t, m_sc, m_ac, m_bc;
  bit m_run, m_bl, r_a, r_s, r_d;

  stopwatch_core #(.SEC_CYCLES(SEC), .ADJ_CYCLES(ADJ), .BLINK_CYCLES(BL)) dut (
    .clk(clk),
    .rst(rst),
    .pause_pulse(pause_pulse),
    .clr_pulse(clr_pulse),
    .adj(adj),
    .sel(sel),
`ifdef COUNTDOWN_EN
    .dir(dir),
    .done(done),
`endif
    .sec_ones(sec_ones),
    .sec_tens(sec_tens),
    .min_ones(min_ones),
    .min_tens(min_tens),
    .running(running),
    .blink(blink),
    .wrap(wrap)
  );
`ifndef COUNTDOWN_EN
  assign done = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference: time kept as total seconds; digits derived by division.
  task automatic model(input bit r, pp, cp, a, s, d);
    bit run, st, at, bt, wr, dn;
    int mm, ss;
    exp_t e;
    wr = 0;
    dn = 0;
    if (r) begin
      m_t = 0; m_run = 1; m_sc = 0; m_ac = 0; m_bc = 0; m_bl = 0;
    end else begin
      run = m_run && !a;
      st = run && m_sc == SEC - 1;
      at = a && m_ac == ADJ - 1;
      bt = a && m_bc == BL - 1;
      if (pp) m_run = !m_run;
      m_sc = (run && !cp && !st) ? m_sc + 1 : 0;
      m_ac = (a && !cp && !at) ? m_ac + 1 : 0;
      m_bc = (a && !cp && !bt) ? m_bc + 1 : 0;
      m_bl = a && (m_bl ^ (bt && !cp));
      if (cp) m_t = 0;
      else if (st) begin
        if (CD && d) begin
          if (m_t == 0) begin m_run = 0; dn = 1; end
          else m_t = m_t - 1;
        end else begin
          m_t = (m_t + 1) % 6000;
          wr = m_t == 0;
        end
      end else if (at) begin
        if (s) m_t = ((m_t / 60 + 1) % 100) * 60 + m_t % 60;
        else m_t = (m_t / 60) * 60 + (m_t % 60 + 1) % 60;
      end
    end
    mm = m_t / 60;
    ss = m_t % 60;
    e.dig = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    e.run = m_run && !a;
    e.bl = a && m_bl;
    e.wr = wr;
    e.dn = dn;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit r, pp, cp, a, s, d);
    @(negedge clk);
    rst = r; pause_pulse = pp; clr_pulse = cp; adj = a; sel = s; dir = d;
    model(rst, pause_pulse, clr_pulse, adj, sel, dir);
  endtask

  task automatic hold(input int n, input bit a, s, d);
    repeat (n) drive(0, 0, 0, a, s, d);
  endtask

  task automatic check_time(input string name, input int mm, ss, input bit run, wr);
    @(posedge clk);
    #2;
    n_cmp++;
    if ({min_tens, min_ones, sec_tens, sec_ones, running, wrap} !==
        {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), run, wr}) begin
      n_bad++;
      $display("FAIL %s: got %h%h:%h%h running=%b wrap=%b, required %02d:%02d running=%b wrap=%b",
               name, min_tens, min_ones, sec_tens, sec_ones, running, wrap, mm, ss, run, wr);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e, g;
      e = exp_q.pop_front();
      g = {min_tens, min_ones, sec_tens, sec_ones, running, blink, wrap, done};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL scoreboard @%0t: got %h:%h run=%b blink=%b wrap=%b done=%b, required %h:%h run=%b blink=%b wrap=%b done=%b",
                 $time, g.dig[15:8], g.dig[7:0], g.run, g.bl, g.wr, g.dn,
                 e.dig[15:8], e.dig[7:0], e.run, e.bl, e.wr, e.dn);
      end
    end
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    check_time("reset", 0, 0, 1, 0);
    check_bit("reset_blink", blink, 1'b0);
    hold(40, 0, 0, 0);
    check_time("run_40", 0, 10, 1, 0);
    hold(297, 1, 1, 0);
    check_time("adj_min_99", 99, 10, 0, 0);
    hold(144, 1, 0, 0);
    check_time("adj_sec_58", 99, 58, 0, 0);
    hold(4, 0, 0, 0);
    check_time("pre_wrap", 99, 59, 1, 0);
    hold(4, 0, 0, 0);
    check_time("wrap", 0, 0, 1, 1);
    hold(1, 0, 0, 0);
    check_time("wrap_end", 0, 0, 1, 0);
    hold(11, 0, 0, 0);
    check_time("pre_pause", 0, 3, 1, 0);
    drive(0, 1, 0, 0, 0, 0);
    hold(20, 0, 0, 0);
    check_time("paused", 0, 3, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    hold(3, 0, 0, 0);
    check_time("resume_3", 0, 3, 1, 0);
    hold(1, 0, 0, 0);
    check_time("resume_4", 0, 4, 1, 0);
    hold(162, 1, 0, 0);
    check_time("adj_58", 0, 58, 0, 0);
    hold(3, 1, 0, 0);
    check_time("adj_59", 0, 59, 0, 0);
    hold(3, 1, 0, 0);
    check_time("adj_sec_roll", 0, 0, 0, 0);
    hold(6, 1, 1, 0);
    check_time("adj_min_2", 2, 0, 0, 0);
    hold(9, 1, 1, 0);
    hold(27, 1, 0, 0);
    check_time("adj_509", 5, 9, 0, 0);
    hold(3, 0, 0, 0);
    check_time("pre_clr", 5, 9, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    check_time("clr_on_tick", 0, 0, 1, 0);
    hold(6, 1, 0, 0);
    check_time("adj_before_rst", 0, 2, 0, 0);
    check_bit("blink_before_rst", blink, 1'b1);
    drive(1, 0, 0, 1, 0, 0);
    check_time("rst_in_adj", 0, 0, 0, 0);
    check_bit("rst_blink", blink, 1'b0);
    hold(1, 0, 0, 0);
    check_time("rst_run", 0, 0, 1, 0);
`ifdef COUNTDOWN_EN
    hold(6, 1, 0, 1);
    check_time("cd_preload", 0, 2, 0, 0);
    hold(4, 0, 0, 1);
    check_time("cd_1", 0, 1, 1, 0);
    hold(4, 0, 0, 1);
    check_time("cd_0", 0, 0, 1, 0);
    hold(4, 0, 0, 1);
    check_time("cd_stop", 0, 0, 0, 0);
    check_bit("cd_done", done, 1'b1);
    hold(1, 0, 0, 1);
    check_time("cd_hold", 0, 0, 0, 0);
    check_bit("cd_done_end", done, 1'b0);
    drive(0, 1, 0, 0, 0, 0);
`endif
    r_a = 0; r_s = 0; r_d = 0;
    repeat (3000) begin
      if ($urandom_range(59) == 0) r_a = !r_a;
      if ($urandom_range(29) == 0) r_s = !r_s;
      if ($urandom_range(79) == 0) r_d = !r_d;
      drive($urandom_range(499) == 0, $urandom_range(24) == 0, $urandom_range(49) == 0, r_a, r_s, r_d);
    end
    @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
